// File: rtl/hazard_unit_pkg.sv
// Shared encodings for the pipeline hazard controller: mux selects, memory FSM states
// and the per-stage stall/flush bundle.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    FwdRf  = 2'b00,
    FwdWb  = 2'b01,
    FwdMem = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    PcPlus4  = 2'b00,
    PcBranch = 2'b01,
    PcJalr   = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    StRun,
    StWait,
    StHalt
  } mem_state_e;

  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic flush_id;
    logic flush_ex;
    logic bubble_wb;
  } stage_ctrl_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle: stage register ids and flags in, mux selects,
// stage controls and performance counters out.
interface hazard_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       i_id_rs1, i_id_rs2;
  logic             i_id_rs1_used, i_id_rs2_used;
  logic [4:0]       i_ex_rs1, i_ex_rs2, i_ex_rd;
  logic             i_ex_regwrite, i_ex_memread;
  logic             i_ex_branch_taken, i_ex_jal, i_ex_jalr;
  logic [4:0]       i_mem_rd;
  logic             i_mem_regwrite;
  logic [4:0]       i_wb_rd;
  logic             i_wb_regwrite;
  logic             i_dmem_req, i_dmem_ready;
  logic [1:0]       o_fwd_a_sel, o_fwd_b_sel, o_pc_sel;
  logic             o_stall_if, o_stall_id, o_stall_ex, o_stall_mem;
  logic             o_flush_id, o_flush_ex, o_bubble_wb, o_halt_err;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

  modport master (
    output i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
    output i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_regwrite, i_ex_memread,
    output i_ex_branch_taken, i_ex_jal, i_ex_jalr,
    output i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite, i_dmem_req, i_dmem_ready,
    input  o_fwd_a_sel, o_fwd_b_sel, o_pc_sel,
    input  o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
    input  o_flush_id, o_flush_ex, o_bubble_wb, o_halt_err, o_stall_cnt, o_flush_cnt
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
    input  i_ex_rs1, i_ex_rs2, i_ex_rd, i_ex_regwrite, i_ex_memread,
    input  i_ex_branch_taken, i_ex_jal, i_ex_jalr,
    input  i_mem_rd, i_mem_regwrite, i_wb_rd, i_wb_regwrite, i_dmem_req, i_dmem_ready,
    output o_fwd_a_sel, o_fwd_b_sel, o_pc_sel,
    output o_stall_if, o_stall_id, o_stall_ex, o_stall_mem,
    output o_flush_id, o_flush_ex, o_bubble_wb, o_halt_err, o_stall_cnt, o_flush_cnt
  );

endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// Forwarding select for one ALU operand; the MEM-stage producer is younger and wins.
module hazard_unit_fwd_sel
  import hazard_unit_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_regwrite,
  input  logic [4:0] i_wb_rd,
  input  logic       i_wb_regwrite,
  output fwd_sel_e   o_sel
);

  always_comb begin
    o_sel = FwdRf;
    if (i_mem_regwrite && (i_mem_rd != 5'd0) && (i_mem_rd == i_src)) begin
      o_sel = FwdMem;
    end else if (i_wb_regwrite && (i_wb_rd != 5'd0) && (i_wb_rd == i_src)) begin
      o_sel = FwdWb;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Five-stage pipeline hazard controller: operand forwarding, redirect flushes, load-use
// stalls, data-memory wait/timeout sequencing and stall/flush performance counters.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic         clk,
  input  logic         rstn,
  hazard_unit_if.slave bus
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  mem_state_e       r_state, w_state_d;
  logic [WaitW-1:0] r_wait_cnt, w_wait_cnt_d;
  logic             r_halt_err;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  fwd_sel_e    w_fwd_a, w_fwd_b;
  pc_sel_e     w_pc_sel;
  stage_ctrl_t w_ctrl, w_ctrl_out;
  logic        w_mem_miss, w_freeze, w_redirect, w_load_use;

  hazard_unit_fwd_sel u_fwd_sel_a (
    .i_src          (bus.i_ex_rs1),
    .i_mem_rd       (bus.i_mem_rd),
    .i_mem_regwrite (bus.i_mem_regwrite),
    .i_wb_rd        (bus.i_wb_rd),
    .i_wb_regwrite  (bus.i_wb_regwrite),
    .o_sel          (w_fwd_a)
  );

  hazard_unit_fwd_sel u_fwd_sel_b (
    .i_src          (bus.i_ex_rs2),
    .i_mem_rd       (bus.i_mem_rd),
    .i_mem_regwrite (bus.i_mem_regwrite),
    .i_wb_rd        (bus.i_wb_rd),
    .i_wb_regwrite  (bus.i_wb_regwrite),
    .o_sel          (w_fwd_b)
  );

  assign w_mem_miss = bus.i_dmem_req & ~bus.i_dmem_ready;
  assign w_freeze   = w_mem_miss | (r_state == StHalt);
  assign w_redirect = ~w_freeze & (bus.i_ex_jalr | bus.i_ex_branch_taken | bus.i_ex_jal);
  assign w_load_use = ~w_freeze & ~w_redirect & bus.i_ex_memread & (bus.i_ex_rd != 5'd0) &
                      ((bus.i_id_rs1_used & (bus.i_ex_rd == bus.i_id_rs1)) |
                       (bus.i_id_rs2_used & (bus.i_ex_rd == bus.i_id_rs2)));

  always_comb begin
    w_ctrl   = '0;
    w_pc_sel = PcPlus4;
    if (w_freeze) begin
      w_ctrl.stall_if  = 1'b1;
      w_ctrl.stall_id  = 1'b1;
      w_ctrl.stall_ex  = 1'b1;
      w_ctrl.stall_mem = 1'b1;
      w_ctrl.bubble_wb = 1'b1;
    end else if (w_redirect) begin
      w_pc_sel        = bus.i_ex_jalr ? PcJalr : PcBranch;
      w_ctrl.flush_id = 1'b1;
      w_ctrl.flush_ex = 1'b1;
    end else if (w_load_use) begin
      w_ctrl.stall_if = 1'b1;
      w_ctrl.stall_id = 1'b1;
      w_ctrl.flush_ex = 1'b1;
    end
  end

  // Wait counter holds the number of consecutive not-ready cycles seen so far.
  always_comb begin
    w_state_d    = r_state;
    w_wait_cnt_d = r_wait_cnt;
    unique case (r_state)
      StRun: begin
        if (w_mem_miss) begin
          w_wait_cnt_d = WaitW'(1);
          w_state_d    = (MAX_WAIT <= 1) ? StHalt : StWait;
        end
      end
      StWait: begin
        if (bus.i_dmem_ready) begin
          w_state_d    = StRun;
          w_wait_cnt_d = '0;
        end else if ((r_wait_cnt + 1'b1) >= WaitMax) begin
          w_state_d    = StHalt;
          w_wait_cnt_d = WaitMax;
        end else begin
          w_wait_cnt_d = r_wait_cnt + 1'b1;
        end
      end
      StHalt: ;
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StRun;
      r_wait_cnt  <= '0;
      r_halt_err  <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_d;
      r_wait_cnt  <= w_wait_cnt_d;
      r_halt_err  <= r_halt_err | (w_state_d == StHalt);
      r_stall_cnt <= r_stall_cnt + CNT_W'(w_ctrl.stall_if);
      r_flush_cnt <= r_flush_cnt + CNT_W'(w_ctrl.flush_ex);
    end
  end

  // Combinational controls are held quiet while reset is asserted.
  assign w_ctrl_out      = rstn ? w_ctrl : '0;
  assign bus.o_fwd_a_sel = rstn ? w_fwd_a : FwdRf;
  assign bus.o_fwd_b_sel = rstn ? w_fwd_b : FwdRf;
  assign bus.o_pc_sel    = rstn ? w_pc_sel : PcPlus4;
  assign bus.o_stall_if  = w_ctrl_out.stall_if;
  assign bus.o_stall_id  = w_ctrl_out.stall_id;
  assign bus.o_stall_ex  = w_ctrl_out.stall_ex;
  assign bus.o_stall_mem = w_ctrl_out.stall_mem;
  assign bus.o_flush_id  = w_ctrl_out.flush_id;
  assign bus.o_flush_ex  = w_ctrl_out.flush_ex;
  assign bus.o_bubble_wb = w_ctrl_out.bubble_wb;
  assign bus.o_halt_err  = r_halt_err;
  assign bus.o_stall_cnt = r_stall_cnt;
  assign bus.o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed and random stimulus, expected outputs queued
// by a reference model and compared by an independent monitor each cycle.
module tb_hazard_unit;
  localparam int unsigned MaxWait = 16;
  localparam int unsigned CntW    = 4;

  typedef struct packed {
    logic [4:0] id_rs1, id_rs2;
    logic       id_rs1_used, id_rs2_used;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_regwrite, ex_memread, ex_branch_taken, ex_jal, ex_jalr;
    logic [4:0] mem_rd;
    logic       mem_regwrite;
    logic [4:0] wb_rd;
    logic       wb_regwrite, dmem_req, dmem_ready;
  } in_t;

  typedef struct packed {
    logic [1:0]      fwd_a, fwd_b, pc_sel;
    logic            stall_if, stall_id, stall_ex, stall_mem;
    logic            flush_id, flush_ex, bubble_wb, halt_err;
    logic [CntW-1:0] stall_cnt, flush_cnt;
  } out_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  out_t exp_q[$];

  // Reference state: consecutive not-ready count, halted flag, event counts.
  int m_wait = 0;
  bit m_halted = 1'b0;
  int m_stalls = 0;
  int m_flushes = 0;

  hazard_unit_if #(.CNT_W(CntW)) bus ();

  hazard_unit #(.MAX_WAIT(MaxWait), .CNT_W(CntW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] src, input in_t v);
    if (v.mem_regwrite && v.mem_rd != 0 && v.mem_rd == src) return 2'd2;
    if (v.wb_regwrite && v.wb_rd != 0 && v.wb_rd == src) return 2'd1;
    return 2'd0;
  endfunction

  function automatic out_t model_out(input in_t v, input bit rst);
    out_t o = '0;
    bit frozen, redirect, hazard;
    if (rst) return o;
    o.fwd_a = fwd_ref(v.ex_rs1, v);
    o.fwd_b = fwd_ref(v.ex_rs2, v);
    frozen   = (v.dmem_req && !v.dmem_ready) || m_halted;
    redirect = v.ex_jalr || v.ex_branch_taken || v.ex_jal;
    hazard   = v.ex_memread && v.ex_rd != 0 &&
               ((v.id_rs1_used && v.id_rs1 == v.ex_rd) || (v.id_rs2_used && v.id_rs2 == v.ex_rd));
    if (frozen) begin
      {o.stall_if, o.stall_id, o.stall_ex, o.stall_mem, o.bubble_wb} = 5'b11111;
    end else if (redirect) begin
      o.pc_sel   = v.ex_jalr ? 2'd2 : 2'd1;
      o.flush_id = 1'b1;
      o.flush_ex = 1'b1;
    end else if (hazard) begin
      o.stall_if = 1'b1;
      o.stall_id = 1'b1;
      o.flush_ex = 1'b1;
    end
    o.halt_err  = m_halted;
    o.stall_cnt = CntW'(m_stalls);
    o.flush_cnt = CntW'(m_flushes);
    return o;
  endfunction

  task automatic model_adv(input in_t v, input out_t o, input bit rst);
    if (rst) begin
      m_wait = 0; m_halted = 0; m_stalls = 0; m_flushes = 0;
      return;
    end
    m_stalls  = (m_stalls + int'(o.stall_if)) % (1 << CntW);
    m_flushes = (m_flushes + int'(o.flush_ex)) % (1 << CntW);
    if (!m_halted) begin
      if (m_wait == 0) begin
        if (v.dmem_req && !v.dmem_ready) m_wait = 1;
      end else if (v.dmem_ready) begin
        m_wait = 0;
      end else begin
        m_wait++;
      end
      if (m_wait >= MaxWait) m_halted = 1;
    end
  endtask

  task automatic drive(input in_t v);
    bus.i_id_rs1 = v.id_rs1;             bus.i_id_rs2 = v.id_rs2;
    bus.i_id_rs1_used = v.id_rs1_used;   bus.i_id_rs2_used = v.id_rs2_used;
    bus.i_ex_rs1 = v.ex_rs1;             bus.i_ex_rs2 = v.ex_rs2;
    bus.i_ex_rd = v.ex_rd;               bus.i_ex_regwrite = v.ex_regwrite;
    bus.i_ex_memread = v.ex_memread;     bus.i_ex_branch_taken = v.ex_branch_taken;
    bus.i_ex_jal = v.ex_jal;             bus.i_ex_jalr = v.ex_jalr;
    bus.i_mem_rd = v.mem_rd;             bus.i_mem_regwrite = v.mem_regwrite;
    bus.i_wb_rd = v.wb_rd;               bus.i_wb_regwrite = v.wb_regwrite;
    bus.i_dmem_req = v.dmem_req;         bus.i_dmem_ready = v.dmem_ready;
  endtask

  task automatic step(input in_t v, input bit rst);
    out_t e;
    @(posedge clk);
    #1;
    rstn = !rst;
    drive(v);
    e = model_out(v, rst);
    exp_q.push_back(e);
    model_adv(v, e, rst);
  endtask

  function automatic in_t rand_in();
    in_t v;
    v.id_rs1 = 5'($urandom_range(0, 3));      v.id_rs2 = 5'($urandom_range(0, 3));
    v.id_rs1_used = 1'($urandom);             v.id_rs2_used = 1'($urandom);
    v.ex_rs1 = 5'($urandom_range(0, 3));      v.ex_rs2 = 5'($urandom_range(0, 3));
    v.ex_rd = 5'($urandom_range(0, 3));       v.ex_regwrite = 1'($urandom);
    v.ex_memread = ($urandom_range(0, 2) == 0);
    v.ex_branch_taken = ($urandom_range(0, 7) == 0);
    v.ex_jal = ($urandom_range(0, 11) == 0);  v.ex_jalr = ($urandom_range(0, 11) == 0);
    v.mem_rd = 5'($urandom_range(0, 3));      v.mem_regwrite = 1'($urandom);
    v.wb_rd = 5'($urandom_range(0, 3));       v.wb_regwrite = 1'($urandom);
    v.dmem_req = ($urandom_range(0, 2) == 0); v.dmem_ready = 1'($urandom);
    return v;
  endfunction

  // Monitor: compare DUT outputs against the queued expectation away from the clock edge.
  initial begin
    out_t e;
    out_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {bus.o_fwd_a_sel, bus.o_fwd_b_sel, bus.o_pc_sel, bus.o_stall_if, bus.o_stall_id,
             bus.o_stall_ex, bus.o_stall_mem, bus.o_flush_id, bus.o_flush_ex, bus.o_bubble_wb,
             bus.o_halt_err, bus.o_stall_cnt, bus.o_flush_cnt};
        check("fwd_a_sel", 32'(a.fwd_a), 32'(e.fwd_a));
        check("fwd_b_sel", 32'(a.fwd_b), 32'(e.fwd_b));
        check("pc_sel", 32'(a.pc_sel), 32'(e.pc_sel));
        check("stall_if", 32'(a.stall_if), 32'(e.stall_if));
        check("stall_id", 32'(a.stall_id), 32'(e.stall_id));
        check("stall_ex", 32'(a.stall_ex), 32'(e.stall_ex));
        check("stall_mem", 32'(a.stall_mem), 32'(e.stall_mem));
        check("flush_id", 32'(a.flush_id), 32'(e.flush_id));
        check("flush_ex", 32'(a.flush_ex), 32'(e.flush_ex));
        check("bubble_wb", 32'(a.bubble_wb), 32'(e.bubble_wb));
        check("halt_err", 32'(a.halt_err), 32'(e.halt_err));
        check("stall_cnt", 32'(a.stall_cnt), 32'(e.stall_cnt));
        check("flush_cnt", 32'(a.flush_cnt), 32'(e.flush_cnt));
      end
    end
  end

  initial begin
    in_t v;
    drive('0);
    repeat (2) step(rand_in(), 1'b1);

    // Forwarding: MEM match, WB only, rd=0, and MEM-over-WB priority.
    v = '0; v.ex_rs1 = 5'd1; v.ex_rs2 = 5'd2; v.mem_rd = 5'd1; v.mem_regwrite = 1'b1;
    step(v, 1'b0);
    v.mem_regwrite = 1'b0; v.wb_rd = 5'd1; v.wb_regwrite = 1'b1;
    step(v, 1'b0);
    v.ex_rs1 = 5'd0; v.mem_rd = 5'd0; v.mem_regwrite = 1'b1; v.wb_rd = 5'd0;
    step(v, 1'b0);
    v.ex_rs2 = 5'd2; v.mem_rd = 5'd2; v.wb_rd = 5'd2;
    step(v, 1'b0);

    // Load-use: one bubble, then the pipeline proceeds.
    v = '0; v.ex_memread = 1'b1; v.ex_rd = 5'd5; v.id_rs1 = 5'd5; v.id_rs1_used = 1'b1;
    step(v, 1'b0);
    step('0, 1'b0);
    #1;
    check("loaduse_stall_cnt", 32'(bus.o_stall_cnt), 32'd1);
    check("loaduse_flush_cnt", 32'(bus.o_flush_cnt), 32'd1);

    v = '0; v.ex_jalr = 1'b1; v.ex_branch_taken = 1'b1;
    step(v, 1'b0);
    v.ex_jalr = 1'b0;
    step(v, 1'b0);

    // Three wait cycles with a pending branch, then ready releases the redirect.
    step('0, 1'b1);
    v = '0; v.ex_branch_taken = 1'b1; v.dmem_req = 1'b1;
    repeat (3) step(v, 1'b0);
    v.dmem_ready = 1'b1;
    step(v, 1'b0);
    step('0, 1'b0);
    #1;
    check("memwait_stall_cnt", 32'(bus.o_stall_cnt), 32'd3);

    for (int i = 0; i < 400; i++) begin
      v = rand_in();
      if (m_wait != 0) v.dmem_req = 1'b1;
      step(v, 1'b0);
    end

    // Timeout: ready never arrives.
    step('0, 1'b1);
    v = '0; v.dmem_req = 1'b1;
    repeat (MaxWait) step(v, 1'b0);
    step('0, 1'b0);
    #1;
    check("halt_err_set", 32'(bus.o_halt_err), 32'd1);
    check("halt_stall_held", 32'(bus.o_stall_if), 32'd1);
    repeat (3) step(rand_in(), 1'b0);
    step(rand_in(), 1'b1);
    step('0, 1'b0);

    // Counter wrap: 17 stall cycles on a 4-bit counter.
    step('0, 1'b1);
    v = '0; v.ex_memread = 1'b1; v.ex_rd = 5'd3; v.id_rs2 = 5'd3; v.id_rs2_used = 1'b1;
    repeat (17) step(v, 1'b0);
    step('0, 1'b0);
    #1;
    check("wrap_stall_cnt", 32'(bus.o_stall_cnt), 32'd1);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
